// File: rtl/tm_warp_dispatcher.sv
// Task-manager launch dispatcher: queues software-warp launches, binds each to the lowest
// free hardware warp slot, runs the RAU allocation handshake and tracks slot occupancy.
module tm_warp_dispatcher #(
  parameter int NUM_HW_WARPS = 8,
  parameter int SW_ID_W      = 1,
  parameter int QDEPTH       = 4,
  parameter int TIMEOUT      = 63
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_Launch_Valid,
  input  logic [SW_ID_W-1:0]      i_Launch_SWWarp,
  input  logic [2:0]              i_Launch_Nreq,
  output logic                    o_Launch_Ready,
  output logic                    o_AlloEN_TM_RAU,
  output logic [2:0]              o_Nreq_TM_RAU,
  output logic [2:0]              o_HWWarp_TM_RAU,
  output logic [SW_ID_W-1:0]      o_SWWarp_TM_RAU,
  input  logic [4:0]              i_Available_RAU_TM,
  input  logic                    i_Req_Done,
  input  logic                    i_ExitEN_IB_RAU,
  input  logic [2:0]              i_ExitWarpID_IB_RAU,
  output logic [NUM_HW_WARPS-1:0] o_WarpActive,
  output logic                    o_Dispatch_Valid,
  output logic [2:0]              o_Dispatch_HWWarp,
  output logic [SW_ID_W-1:0]      o_Dispatch_SWWarp,
  output logic                    o_Err_Timeout,
  output logic                    o_Err_SpurExit
);

  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_COMMIT} state_t;

  state_t                    r_state;
  logic [SW_ID_W+2:0]        r_fifo [QDEPTH];
  logic [QAW:0]              r_wptr, r_rptr;
  logic [CW-1:0]             r_wait_cnt;
  logic [NUM_HW_WARPS-1:0]   r_warp_active;
  logic                      r_allo_en, r_disp_valid, r_err_to, r_err_spur;
  logic [2:0]                r_nreq_tm, r_hw_tm, r_disp_hw;
  logic [SW_ID_W-1:0]        r_sw_tm, r_disp_sw;

  logic [QAW:0]              w_count;
  logic                      w_full, w_empty, w_push;
  logic [2:0]                w_head_nreq;
  logic [SW_ID_W-1:0]        w_head_sw;
  logic [3:0]                w_need;
  logic                      w_eligible, w_commit;
  logic [2:0]                w_free_slot, w_commit_slot;
  logic [SW_ID_W-1:0]        w_commit_sw;
  logic [NUM_HW_WARPS-1:0]   w_mask_next;

  assign w_count     = r_wptr - r_rptr;
  assign w_full      = (w_count == (QAW+1)'(QDEPTH));
  assign w_empty     = (r_wptr == r_rptr);
  assign w_push      = i_Launch_Valid & ~w_full;
  assign w_head_nreq = r_fifo[r_rptr[QAW-1:0]][2:0];
  assign w_head_sw   = r_fifo[r_rptr[QAW-1:0]][SW_ID_W+2:3];
  // RAU hands out registers in pairs, so an odd request consumes one extra.
  assign w_need      = {1'b0, w_head_nreq} + {3'b000, w_head_nreq[0]};

  assign w_eligible = ~w_empty & ~(&r_warp_active) &
                      ({1'b0, w_need} <= i_Available_RAU_TM) & ~i_ExitEN_IB_RAU;
  assign w_commit   = ((r_state == S_IDLE) & w_eligible & (w_head_nreq == 3'd0)) |
                      ((r_state == S_WAIT) & i_Req_Done);
  assign w_commit_slot = (r_state == S_IDLE) ? w_free_slot : r_hw_tm;
  assign w_commit_sw   = (r_state == S_IDLE) ? w_head_sw   : r_sw_tm;

  // Lowest-index inactive hardware warp slot.
  always_comb begin
    w_free_slot = 3'd0;
    for (int i = NUM_HW_WARPS - 1; i >= 0; i--) begin
      if (!r_warp_active[i]) begin
        w_free_slot = 3'(i);
      end else begin
        w_free_slot = w_free_slot;
      end
    end
  end

  // Exit clears its slot first so a same-edge commit to that slot wins.
  always_comb begin
    w_mask_next = r_warp_active;
    if (i_ExitEN_IB_RAU) begin
      w_mask_next[i_ExitWarpID_IB_RAU] = 1'b0;
    end else begin
      w_mask_next = w_mask_next;
    end
    if (w_commit) begin
      w_mask_next[w_commit_slot] = 1'b1;
    end else begin
      w_mask_next = w_mask_next;
    end
  end

  // Launch FIFO storage; occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr[QAW-1:0]] <= {i_Launch_SWWarp, i_Launch_Nreq};
    end
  end

  // Allocation FSM, FIFO pointers, slot mask and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_wait_cnt    <= '0;
      r_warp_active <= '0;
      r_allo_en     <= 1'b0;
      r_nreq_tm     <= 3'd0;
      r_hw_tm       <= 3'd0;
      r_sw_tm       <= '0;
      r_disp_valid  <= 1'b0;
      r_disp_hw     <= 3'd0;
      r_disp_sw     <= '0;
      r_err_to      <= 1'b0;
      r_err_spur    <= 1'b0;
    end else begin
      r_allo_en     <= 1'b0;
      r_disp_valid  <= w_commit;
      r_disp_hw     <= w_commit ? w_commit_slot : 3'd0;
      r_disp_sw     <= w_commit ? w_commit_sw : '0;
      r_warp_active <= w_mask_next;
      if (w_push)   r_wptr <= r_wptr + 1'b1;
      if (w_commit) r_rptr <= r_rptr + 1'b1;
      if (i_ExitEN_IB_RAU && !r_warp_active[i_ExitWarpID_IB_RAU]) r_err_spur <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_eligible && (w_head_nreq == 3'd0)) begin
            r_state <= S_COMMIT;
          end else if (w_eligible) begin
            r_state   <= S_REQ;
            r_allo_en <= 1'b1;
            r_nreq_tm <= w_head_nreq;
            r_hw_tm   <= w_free_slot;
            r_sw_tm   <= w_head_sw;
          end
        end
        S_REQ: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (i_Req_Done || (r_wait_cnt == CW'(TIMEOUT - 1))) begin
            r_state   <= i_Req_Done ? S_COMMIT : S_IDLE;
            r_err_to  <= r_err_to | ~i_Req_Done;
            r_nreq_tm <= 3'd0;
            r_hw_tm   <= 3'd0;
            r_sw_tm   <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_COMMIT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Launch_Ready    = ~w_full;
  assign o_AlloEN_TM_RAU   = r_allo_en;
  assign o_Nreq_TM_RAU     = r_nreq_tm;
  assign o_HWWarp_TM_RAU   = r_hw_tm;
  assign o_SWWarp_TM_RAU   = r_sw_tm;
  assign o_WarpActive      = r_warp_active;
  assign o_Dispatch_Valid  = r_disp_valid;
  assign o_Dispatch_HWWarp = r_disp_hw;
  assign o_Dispatch_SWWarp = r_disp_sw;
  assign o_Err_Timeout     = r_err_to;
  assign o_Err_SpurExit    = r_err_spur;

endmodule

// File: tb/tb_tm_warp_dispatcher.sv
// Bench for tm_warp_dispatcher: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tm_warp_dispatcher;

  localparam int TIMEOUT = 63;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_Launch_Valid;
  logic [0:0] i_Launch_SWWarp;
  logic [2:0] i_Launch_Nreq;
  logic [4:0] i_Available_RAU_TM;
  logic       i_Req_Done, i_ExitEN_IB_RAU;
  logic [2:0] i_ExitWarpID_IB_RAU;
  logic       o_Launch_Ready, o_AlloEN_TM_RAU, o_Dispatch_Valid, o_Err_Timeout, o_Err_SpurExit;
  logic [2:0] o_Nreq_TM_RAU, o_HWWarp_TM_RAU, o_Dispatch_HWWarp;
  logic [0:0] o_SWWarp_TM_RAU, o_Dispatch_SWWarp;
  logic [7:0] o_WarpActive;

  always #5 clk = ~clk;

  tm_warp_dispatcher dut (
    .clk(clk), .rst(rst),
    .i_Launch_Valid(i_Launch_Valid), .i_Launch_SWWarp(i_Launch_SWWarp), .i_Launch_Nreq(i_Launch_Nreq),
    .o_Launch_Ready(o_Launch_Ready),
    .o_AlloEN_TM_RAU(o_AlloEN_TM_RAU), .o_Nreq_TM_RAU(o_Nreq_TM_RAU),
    .o_HWWarp_TM_RAU(o_HWWarp_TM_RAU), .o_SWWarp_TM_RAU(o_SWWarp_TM_RAU),
    .i_Available_RAU_TM(i_Available_RAU_TM), .i_Req_Done(i_Req_Done),
    .i_ExitEN_IB_RAU(i_ExitEN_IB_RAU), .i_ExitWarpID_IB_RAU(i_ExitWarpID_IB_RAU),
    .o_WarpActive(o_WarpActive), .o_Dispatch_Valid(o_Dispatch_Valid),
    .o_Dispatch_HWWarp(o_Dispatch_HWWarp), .o_Dispatch_SWWarp(o_Dispatch_SWWarp),
    .o_Err_Timeout(o_Err_Timeout), .o_Err_SpurExit(o_Err_SpurExit)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending launches, occupied slots, and the in-flight allocation.
  int         q_sw[$];
  int         q_nreq[$];
  logic [7:0] m_act;
  int         m_phase;   // 0 idle, 1 request issued, 2 waiting on RAU, 3 dispatched
  int         m_slot, m_sw, m_nreq, m_waited;
  bit         m_err_to, m_err_spur, m_disp;
  int         m_disp_hw, m_disp_sw;

  function automatic int need_of(int n);
    return n + (n % 2);
  endfunction

  function automatic int lowest_free(logic [7:0] a);
    logic [7:0] iso;
    iso = ~a & (a + 8'd1);
    for (int i = 0; i < 8; i++) if (iso[i]) return i;
    return 0;
  endfunction

  task automatic cmp(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_sw.delete(); q_nreq.delete();
    m_act = 8'h00; m_phase = 0; m_slot = 0; m_sw = 0; m_nreq = 0; m_waited = 0;
    m_err_to = 0; m_err_spur = 0; m_disp = 0; m_disp_hw = 0; m_disp_sw = 0;
  endtask

  task automatic model_step();
    bit commit;
    int cs, csw, held;
    bit room;
    commit = 0; cs = 0; csw = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    held = q_sw.size();
    room = (held < 4);
    m_disp = 0;
    case (m_phase)
      0: begin
        if (held > 0) begin
          if (m_act != 8'hFF && need_of(q_nreq[0]) <= int'(i_Available_RAU_TM) && !i_ExitEN_IB_RAU) begin
            cs = lowest_free(m_act);
            if (q_nreq[0] == 0) begin
              commit = 1; csw = q_sw[0]; m_phase = 3;
            end else begin
              m_slot = cs; m_sw = q_sw[0]; m_nreq = q_nreq[0]; m_phase = 1;
            end
          end
        end
      end
      1: begin m_phase = 2; m_waited = 0; end
      2: begin
        m_waited++;
        if (i_Req_Done) begin
          commit = 1; cs = m_slot; csw = m_sw; m_phase = 3;
        end else if (m_waited == TIMEOUT) begin
          m_err_to = 1; m_phase = 0;
        end
      end
      default: m_phase = 0;
    endcase
    if (i_ExitEN_IB_RAU) begin
      if (!m_act[i_ExitWarpID_IB_RAU]) m_err_spur = 1;
      else m_act[i_ExitWarpID_IB_RAU] = 1'b0;
    end
    if (commit) begin
      m_act[cs] = 1'b1;
      void'(q_sw.pop_front()); void'(q_nreq.pop_front());
      m_disp = 1; m_disp_hw = cs; m_disp_sw = csw;
    end
    if (i_Launch_Valid && room) begin
      q_sw.push_back(int'(i_Launch_SWWarp)); q_nreq.push_back(int'(i_Launch_Nreq));
    end
  endtask

  task automatic check_all();
    bit rau_busy;
    rau_busy = (m_phase == 1 || m_phase == 2);
    cmp("ready",   o_Launch_Ready,  q_sw.size() < 4);
    cmp("alloen",  o_AlloEN_TM_RAU, m_phase == 1);
    cmp("rau_nreq", o_Nreq_TM_RAU,  rau_busy ? m_nreq : 0);
    cmp("rau_hw",  o_HWWarp_TM_RAU, rau_busy ? m_slot : 0);
    cmp("rau_sw",  o_SWWarp_TM_RAU, rau_busy ? m_sw : 0);
    cmp("mask",    o_WarpActive,    m_act);
    cmp("disp_v",  o_Dispatch_Valid, m_disp);
    if (m_disp) begin
      cmp("disp_hw", o_Dispatch_HWWarp, m_disp_hw);
      cmp("disp_sw", o_Dispatch_SWWarp, m_disp_sw);
    end
    cmp("err_to",   o_Err_Timeout,  m_err_to);
    cmp("err_spur", o_Err_SpurExit, m_err_spur);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet();
    i_Launch_Valid = 1'b0; i_Req_Done = 1'b0; i_ExitEN_IB_RAU = 1'b0;
  endtask

  task automatic push(input int sw, input int nreq);
    i_Launch_Valid = 1'b1; i_Launch_SWWarp = 1'(sw); i_Launch_Nreq = 3'(nreq);
  endtask

  task automatic do_exit(input int id);
    i_ExitEN_IB_RAU = 1'b1; i_ExitWarpID_IB_RAU = 3'(id);
  endtask

  initial begin
    model_reset();
    rst = 1'b0; quiet();
    i_Launch_SWWarp = 1'b0; i_Launch_Nreq = 3'd0; i_ExitWarpID_IB_RAU = 3'd0;
    i_Available_RAU_TM = 5'd16;
    tick(); tick();
    cmp("rst_ready", o_Launch_Ready, 1);
    cmp("rst_mask", o_WarpActive, 0);
    rst = 1'b1;

    // 1: basic allocation, Req_Done two cycles after AlloEN
    push(1, 3); tick();
    cmp("t1_no_alloen_yet", o_AlloEN_TM_RAU, 0);
    quiet(); tick();
    cmp("t1_alloen", o_AlloEN_TM_RAU, 1);
    cmp("t1_hw", o_HWWarp_TM_RAU, 0);
    cmp("t1_nreq", o_Nreq_TM_RAU, 3);
    cmp("t1_sw", o_SWWarp_TM_RAU, 1);
    tick();
    cmp("t1_alloen_once", o_AlloEN_TM_RAU, 0);
    i_Req_Done = 1'b1; tick();
    cmp("t1_disp", o_Dispatch_Valid, 1);
    cmp("t1_disp_hw", o_Dispatch_HWWarp, 0);
    cmp("t1_mask", o_WarpActive, 8'h01);
    quiet(); tick();
    cmp("t1_disp_pulse", o_Dispatch_Valid, 0);

    // 2: insufficient registers hold the launch in idle
    i_Available_RAU_TM = 5'd5; push(0, 7); tick(); quiet();
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("t2_held", o_AlloEN_TM_RAU, 0);
    end
    i_Available_RAU_TM = 5'd8; tick();
    cmp("t2_alloen", o_AlloEN_TM_RAU, 1);
    cmp("t2_hw", o_HWWarp_TM_RAU, 1);
    tick(); i_Req_Done = 1'b1; tick(); quiet();
    cmp("t2_mask", o_WarpActive, 8'h03);
    tick();

    // spurious exit on an inactive slot
    do_exit(7); tick(); quiet();
    cmp("spur_flag", o_Err_SpurExit, 1);
    cmp("spur_mask", o_WarpActive, 8'h03);

    // 3: fill every slot with zero-register launches, then free slot 5
    for (int k = 0; k < 6; k++) begin
      push(k % 2, 0); tick(); quiet(); tick(); tick();
    end
    cmp("t3_full", o_WarpActive, 8'hFF);
    push(1, 0); tick(); quiet();
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("t3_blocked", o_Dispatch_Valid, 0);
    end
    do_exit(5); tick(); quiet();
    cmp("t3_exit_mask", o_WarpActive, 8'hDF);
    tick();
    cmp("t3_disp", o_Dispatch_Valid, 1);
    cmp("t3_disp_hw", o_Dispatch_HWWarp, 5);
    cmp("t3_refill", o_WarpActive, 8'hFF);
    tick();

    // 4: exit in the first eligible cycle defers the request by one cycle
    do_exit(6); tick(); quiet();
    push(0, 2); tick(); quiet();
    do_exit(2); tick(); quiet();
    cmp("t4_deferred", o_AlloEN_TM_RAU, 0);
    cmp("t4_mask", o_WarpActive, 8'hBB);
    tick();
    cmp("t4_alloen", o_AlloEN_TM_RAU, 1);
    cmp("t4_hw", o_HWWarp_TM_RAU, 2);

    // 5: RAU never answers
    for (int i = 0; i < TIMEOUT; i++) tick();
    cmp("t5_still_waiting", o_Err_Timeout, 0);
    cmp("t5_hw_stable", o_HWWarp_TM_RAU, 2);
    tick();
    cmp("t5_timeout", o_Err_Timeout, 1);
    cmp("t5_rau_cleared", o_HWWarp_TM_RAU, 0);
    tick();
    cmp("t5_retry", o_AlloEN_TM_RAU, 1);
    cmp("t5_retry_hw", o_HWWarp_TM_RAU, 2);
    tick(); i_Req_Done = 1'b1; tick(); quiet();
    cmp("t5_disp_hw", o_Dispatch_HWWarp, 2);
    cmp("t5_mask", o_WarpActive, 8'hBF);
    tick();

    // 6: back-pressure, then reset during WAIT
    i_Available_RAU_TM = 5'd0;
    for (int i = 0; i < 5; i++) begin
      push(1, 2);
      if (i == 4) cmp("t6_not_ready", o_Launch_Ready, 0);
      tick();
    end
    quiet(); i_Available_RAU_TM = 5'd16; tick();
    cmp("t6_alloen", o_AlloEN_TM_RAU, 1);
    tick();
    rst = 1'b0; tick();
    cmp("t6_rst_ready", o_Launch_Ready, 1);
    cmp("t6_rst_mask", o_WarpActive, 0);
    cmp("t6_rst_err", o_Err_Timeout, 0);
    cmp("t6_rst_hw", o_HWWarp_TM_RAU, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("t6_fifo_empty", o_AlloEN_TM_RAU, 0);
    end

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int r;
      i_Launch_Valid     = 1'($urandom_range(0, 1));
      i_Launch_SWWarp    = 1'($urandom_range(0, 1));
      i_Launch_Nreq      = 3'($urandom_range(0, 7));
      i_Available_RAU_TM = 5'($urandom_range(0, 31));
      i_Req_Done         = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 7);
      i_ExitWarpID_IB_RAU = 3'(r);
      i_ExitEN_IB_RAU    = ($urandom_range(0, 3) == 0) && m_act[r];
      rst                = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
